// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerator types and sizes for the partial-sum global buffer
//
// Purpose: bank-state encoding, buffer geometry and a small helper used by
//          psum_gbf_dbuf and gbf_bank_ram.
package accel_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_DRAIN   = 2'd3
    } bank_state_e;

    localparam int GBF_DATA_BITWIDTH = 512;
    localparam int PSUM_GBF_DEPTH    = 32;

    // A bank accepts accumulator writes only before it has been closed.
    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/gbf_bank_ram.sv
// rtl/gbf_bank_ram.sv - simple dual-port synchronous RAM, one bank of the partial-sum buffer
//
// Purpose: one write port, one read port, registered read data (1-cycle latency).
//          Contents are not reset; rdata_o holds its value while re_i is low.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write strobe, address, data
//   re_i/raddr_i     read strobe, address
//   rdata_o          read data, valid the cycle after re_i
module gbf_bank_ram
    import accel_pkg::*;
#(
    parameter int DATA_BITWIDTH = GBF_DATA_BITWIDTH,
    parameter int DEPTH         = PSUM_GBF_DEPTH,
    parameter int ADDR_BITWIDTH = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [ADDR_BITWIDTH-1:0] waddr_i,
    input  logic [DATA_BITWIDTH-1:0] wdata_i,
    input  logic                     re_i,
    input  logic [ADDR_BITWIDTH-1:0] raddr_i,
    output logic [DATA_BITWIDTH-1:0] rdata_o
);

    logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/psum_gbf_dbuf.sv
// rtl/psum_gbf_dbuf.sv - double-banked partial-sum global buffer between accumulator and drain stream
//
// Purpose: absorbs accumulator row writes into one of two banks, drains each
//          closed bank oldest-first over a valid/ready stream, reports which
//          banks may be written.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   w_en/w_addr/w_num/w_data   accumulator write into bank w_num
//   w_close                    bank w_num is complete
//   bank_free[b]               bank b is EMPTY or FILLING
//   rd_valid/rd_ready          drain stream handshake
//   rd_data/rd_addr/rd_bank/rd_last   drained beat
//   wr_err                     sticky: write/close hit a FULL or DRAIN bank
module psum_gbf_dbuf
    import accel_pkg::*;
#(
    parameter int DATA_BITWIDTH = GBF_DATA_BITWIDTH,
    parameter int DEPTH         = PSUM_GBF_DEPTH,
    parameter int ADDR_BITWIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic                     w_num,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     w_close,
    output logic [1:0]               bank_free,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_BITWIDTH-1:0] rd_data,
    output logic [ADDR_BITWIDTH-1:0] rd_addr,
    output logic                     rd_bank,
    output logic                     rd_last,
    output logic                     wr_err
);

    localparam int LW = ADDR_BITWIDTH + 1;

    // Bank bookkeeping
    bank_state_e        st_q [2];
    bank_state_e        st_d [2];
    logic [LW-1:0]      len_q [2];
    logic [LW-1:0]      len_d [2];
    logic               wr_err_q, wr_err_d;
    logic [1:0]         ram_we;
    logic               enq, enq_bank;

    // Drain-order queue (head at index 0)
    logic               oq_q [2];
    logic               oq_d [2];
    logic [1:0]         oq_cnt_q, oq_cnt_d;
    logic [1:0]         oq_pos;

    // Read issue engine
    logic                     iss_act_q, iss_act_d;
    logic                     iss_bank_q, iss_bank_d;
    logic [ADDR_BITWIDTH-1:0] iss_addr_q, iss_addr_d;
    logic                     pop, can_issue, issue, start;
    logic                     ibank, ilast;
    logic [ADDR_BITWIDTH-1:0] iaddr;
    logic [1:0]               ram_re;
    logic [DATA_BITWIDTH-1:0] ram_rdata [2];

    // RAM-output stage metadata (data itself lives in the RAM read register)
    logic                     p_valid_q, p_valid_d;
    logic                     p_bank_q, p_bank_d;
    logic [ADDR_BITWIDTH-1:0] p_addr_q, p_addr_d;
    logic                     p_last_q, p_last_d;
    logic [DATA_BITWIDTH-1:0] p_data;

    // Output register and skid entry
    logic                     out_valid_q, out_valid_d;
    logic [DATA_BITWIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_BITWIDTH-1:0] out_addr_q, out_addr_d;
    logic                     out_bank_q, out_bank_d;
    logic                     out_last_q, out_last_d;
    logic                     sk_valid_q, sk_valid_d;
    logic [DATA_BITWIDTH-1:0] sk_data_q, sk_data_d;
    logic [ADDR_BITWIDTH-1:0] sk_addr_q, sk_addr_d;
    logic                     sk_bank_q, sk_bank_d;
    logic                     sk_last_q, sk_last_d;

    assign p_data = ram_rdata[p_bank_q];
    assign pop    = out_valid_q && rd_ready;

    // A new read may enter the RAM stage only if, after this edge, the output
    // register and skid can still absorb everything in flight. Invariant: the
    // skid and the RAM stage are never both occupied.
    always_comb begin
        can_issue = pop || !(sk_valid_q || (p_valid_q && out_valid_q));
        issue     = can_issue && (iss_act_q || (oq_cnt_q != 2'd0));
        start     = issue && !iss_act_q;
        ibank     = iss_act_q ? iss_bank_q : oq_q[0];
        iaddr     = iss_act_q ? iss_addr_q : '0;
        ilast     = ({1'b0, iaddr} == (len_q[ibank] - LW'(1)));
        ram_re[0] = issue && !ibank;
        ram_re[1] = issue && ibank;
    end

    always_comb begin
        iss_act_d  = iss_act_q;
        iss_bank_d = iss_bank_q;
        iss_addr_d = iss_addr_q;
        p_valid_d  = issue;
        p_bank_d   = p_bank_q;
        p_addr_d   = p_addr_q;
        p_last_d   = p_last_q;
        if (issue) begin
            iss_act_d  = !ilast;
            iss_bank_d = ibank;
            iss_addr_d = iaddr + ADDR_BITWIDTH'(1);
            p_bank_d   = ibank;
            p_addr_d   = iaddr;
            p_last_d   = ilast;
        end
    end

    // Output register refills from the skid first, then from the RAM stage;
    // while stalled, a beat leaving the RAM stage parks in the skid.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_bank_d  = out_bank_q;
        out_last_d  = out_last_q;
        sk_valid_d  = sk_valid_q;
        sk_data_d   = sk_data_q;
        sk_addr_d   = sk_addr_q;
        sk_bank_d   = sk_bank_q;
        sk_last_d   = sk_last_q;
        if (!out_valid_q || pop) begin
            if (sk_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = sk_data_q;
                out_addr_d  = sk_addr_q;
                out_bank_d  = sk_bank_q;
                out_last_d  = sk_last_q;
                sk_valid_d  = p_valid_q;
                sk_data_d   = p_data;
                sk_addr_d   = p_addr_q;
                sk_bank_d   = p_bank_q;
                sk_last_d   = p_last_q;
            end else begin
                out_valid_d = p_valid_q;
                sk_valid_d  = 1'b0;
                if (p_valid_q) begin
                    out_data_d = p_data;
                    out_addr_d = p_addr_q;
                    out_bank_d = p_bank_q;
                    out_last_d = p_last_q;
                end
            end
        end else if (p_valid_q) begin
            sk_valid_d = 1'b1;
            sk_data_d  = p_data;
            sk_addr_d  = p_addr_q;
            sk_bank_d  = p_bank_q;
            sk_last_d  = p_last_q;
        end
    end

    // Per-bank FSMs. A same-cycle write and close stores the word, counts it
    // in len, then closes. A bank closed with len 0 is never queued and falls
    // back to EMPTY from FULL on the next cycle.
    always_comb begin
        st_d     = st_q;
        len_d    = len_q;
        ram_we   = '0;
        enq      = 1'b0;
        enq_bank = 1'b0;
        wr_err_d = wr_err_q | ((w_en || w_close) && !bank_writable(st_q[w_num]));
        for (int b = 0; b < 2; b++) begin
            unique case (st_q[b])
                BANK_EMPTY, BANK_FILLING: begin
                    if (w_en && (w_num == 1'(b))) begin
                        ram_we[b] = 1'b1;
                        st_d[b]   = BANK_FILLING;
                        if ((LW'(w_addr) + LW'(1)) > len_q[b]) begin
                            len_d[b] = LW'(w_addr) + LW'(1);
                        end
                    end
                    if (w_close && (w_num == 1'(b))) begin
                        st_d[b] = BANK_FULL;
                        if (len_d[b] != '0) begin
                            enq      = 1'b1;
                            enq_bank = 1'(b);
                        end
                    end
                end
                BANK_FULL: begin
                    if (len_q[b] == '0) begin
                        st_d[b] = BANK_EMPTY;
                    end else if (start && (oq_q[0] == 1'(b))) begin
                        st_d[b] = BANK_DRAIN;
                    end
                end
                BANK_DRAIN: begin
                    if (pop && out_last_q && (out_bank_q == 1'(b))) begin
                        st_d[b]  = BANK_EMPTY;
                        len_d[b] = '0;
                    end
                end
                default: st_d[b] = BANK_EMPTY;
            endcase
        end
    end

    // Drain-order queue: pop on drain start, push on close of a non-empty bank.
    always_comb begin
        oq_d     = oq_q;
        oq_pos   = start ? (oq_cnt_q - 2'd1) : oq_cnt_q;
        oq_cnt_d = oq_pos + {1'b0, enq};
        if (start) begin
            oq_d[0] = oq_q[1];
        end
        if (enq) begin
            oq_d[oq_pos[0]] = enq_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= '{BANK_EMPTY, BANK_EMPTY};
            len_q       <= '{'0, '0};
            oq_q        <= '{1'b0, 1'b0};
            oq_cnt_q    <= '0;
            wr_err_q    <= 1'b0;
            iss_act_q   <= 1'b0;
            iss_bank_q  <= 1'b0;
            iss_addr_q  <= '0;
            p_valid_q   <= 1'b0;
            p_bank_q    <= 1'b0;
            p_addr_q    <= '0;
            p_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_bank_q  <= 1'b0;
            out_last_q  <= 1'b0;
            sk_valid_q  <= 1'b0;
            sk_data_q   <= '0;
            sk_addr_q   <= '0;
            sk_bank_q   <= 1'b0;
            sk_last_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            len_q       <= len_d;
            oq_q        <= oq_d;
            oq_cnt_q    <= oq_cnt_d;
            wr_err_q    <= wr_err_d;
            iss_act_q   <= iss_act_d;
            iss_bank_q  <= iss_bank_d;
            iss_addr_q  <= iss_addr_d;
            p_valid_q   <= p_valid_d;
            p_bank_q    <= p_bank_d;
            p_addr_q    <= p_addr_d;
            p_last_q    <= p_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_bank_q  <= out_bank_d;
            out_last_q  <= out_last_d;
            sk_valid_q  <= sk_valid_d;
            sk_data_q   <= sk_data_d;
            sk_addr_q   <= sk_addr_d;
            sk_bank_q   <= sk_bank_d;
            sk_last_q   <= sk_last_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        gbf_bank_ram #(
            .DATA_BITWIDTH(DATA_BITWIDTH),
            .DEPTH        (DEPTH),
            .ADDR_BITWIDTH(ADDR_BITWIDTH)
        ) u_ram (
            .clk_i  (clk),
            .we_i   (ram_we[g]),
            .waddr_i(w_addr),
            .wdata_i(w_data),
            .re_i   (ram_re[g]),
            .raddr_i(iaddr),
            .rdata_o(ram_rdata[g])
        );
    end

    assign bank_free[0] = bank_writable(st_q[0]);
    assign bank_free[1] = bank_writable(st_q[1]);
    assign rd_valid     = out_valid_q;
    assign rd_data      = out_data_q;
    assign rd_addr      = out_addr_q;
    assign rd_bank      = out_bank_q;
    assign rd_last      = out_last_q;
    assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_psum_gbf_dbuf.sv
// tb/tb_psum_gbf_dbuf.sv - scoreboard bench for psum_gbf_dbuf
module tb_psum_gbf_dbuf;

    logic         clk;
    logic         reset;
    logic         w_en;
    logic [4:0]   w_addr;
    logic         w_num;
    logic [511:0] w_data;
    logic         w_close;
    logic [1:0]   bank_free;
    logic         rd_valid;
    logic         rd_ready;
    logic [511:0] rd_data;
    logic [4:0]   rd_addr;
    logic         rd_bank;
    logic         rd_last;
    logic         wr_err;

    typedef struct {
        logic [511:0] d;
        logic [4:0]   a;
        logic         b;
        logic         l;
    } beat_t;

    beat_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b1;

    psum_gbf_dbuf dut (
        .clk      (clk),
        .reset    (reset),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_num    (w_num),
        .w_data   (w_data),
        .w_close  (w_close),
        .bank_free(bank_free),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_addr  (rd_addr),
        .rd_bank  (rd_bank),
        .rd_last  (rd_last),
        .wr_err   (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk(input int v);
        return {16{v[31:0]}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic b, input int a, input int v, input logic cl);
        w_en    = 1'b1;
        w_num   = b;
        w_addr  = a[4:0];
        w_data  = mk(v);
        w_close = cl;
        step();
        w_en    = 1'b0;
        w_close = 1'b0;
    endtask

    task automatic close_bank(input logic b);
        w_close = 1'b1;
        w_num   = b;
        step();
        w_close = 1'b0;
    endtask

    task automatic push(input logic b, input int a, input int v, input logic last);
        beat_t e;
        e.d = mk(v);
        e.a = a[4:0];
        e.b = b;
        e.l = last;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int i;
        i = 0;
        while (sb.size() != 0 && i < limit) begin
            step();
            i++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d beats still pending after %0d cycles, expected 0", name, sb.size(), limit);
        end
    endtask

    // Monitor: whenever a beat is presented it must match the oldest expected
    // beat; it is retired only when accepted, so a stalled beat must hold.
    always @(negedge clk) begin
        if (mon_en && !reset && rd_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got bank %0d addr %0d, expected no beat", rd_bank, rd_addr);
            end else begin
                chk("rd_data", rd_data, sb[0].d);
                chk("rd_addr", rd_addr, sb[0].a);
                chk("rd_bank", rd_bank, sb[0].b);
                chk("rd_last", rd_last, sb[0].l);
                if (rd_ready) sb.delete(0);
            end
        end
    end

    initial begin
        logic [7:0] pat;
        bit         found;
        int         i;

        reset    = 1'b1;
        w_en     = 1'b0;
        w_addr   = '0;
        w_num    = 1'b0;
        w_data   = '0;
        w_close  = 1'b0;
        rd_ready = 1'b1;
        step();
        step();
        chk("reset_bank_free", bank_free, 2'b11);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_last", rd_last, 1'b0);
        chk("reset_rd_addr", rd_addr, 5'd0);
        chk("reset_rd_bank", rd_bank, 1'b0);
        chk("reset_rd_data", rd_data, 512'd0);
        chk("reset_wr_err", wr_err, 1'b0);
        reset = 1'b0;
        step();

        // Full bank 0, data = addr + 100
        for (int a = 0; a < 32; a++) wr(1'b0, a, a + 100, 1'b0);
        chk("fill_bank_free", bank_free, 2'b11);
        for (int a = 0; a < 32; a++) push(1'b0, a, a + 100, a == 31);
        close_bank(1'b0);
        chk("full_bank_free", bank_free, 2'b10);
        step();
        chk("first_valid_c1", rd_valid, 1'b0);
        step();
        chk("first_valid_c2", rd_valid, 1'b1);
        repeat (31) step();
        chk("last_beat_shown", rd_last, 1'b1);
        chk("bank0_busy_at_last", bank_free[0], 1'b0);
        step();
        chk("bank0_free_after_last", bank_free[0], 1'b1);
        chk("idle_after_drain", rd_valid, 1'b0);
        wait_drain("full_drain", 10);

        // Partial bank 1: 5 words
        for (int a = 0; a < 5; a++) wr(1'b1, a, a + 200, 1'b0);
        for (int a = 0; a < 5; a++) push(1'b1, a, a + 200, a == 4);
        close_bank(1'b1);
        wait_drain("partial_drain", 40);
        chk("partial_bank_free", bank_free, 2'b11);

        // Backpressure on bank 0, 8 words
        rd_ready = 1'b0;
        for (int a = 0; a < 8; a++) wr(1'b0, a, a + 300, 1'b0);
        for (int a = 0; a < 8; a++) push(1'b0, a, a + 300, a == 7);
        close_bank(1'b0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (rd_valid) found = 1'b1;
            else step();
        end
        chk("bp_first_valid", found, 1'b1);
        pat = 8'b01101001;
        for (int k = 0; k < 8; k++) begin
            rd_ready = pat[k];
            step();
        end
        rd_ready = 1'b1;
        wait_drain("bp_drain", 40);

        // Ping-pong: bank 1 filled and closed while bank 0 drains
        for (int a = 0; a < 16; a++) wr(1'b0, a, a + 400, 1'b0);
        for (int a = 0; a < 16; a++) push(1'b0, a, a + 400, a == 15);
        close_bank(1'b0);
        for (int a = 0; a < 10; a++) wr(1'b1, a, a + 500, 1'b0);
        for (int a = 0; a < 10; a++) push(1'b1, a, a + 500, a == 9);
        close_bank(1'b1);
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            chk("pingpong_no_bubble", rd_valid, 1'b1);
            step();
            i++;
        end
        wait_drain("pingpong_drain", 10);

        // Error: write into a draining bank; then same-cycle write+close
        for (int a = 0; a < 20; a++) wr(1'b0, a, a + 600, 1'b0);
        for (int a = 0; a < 20; a++) push(1'b0, a, a + 600, a == 19);
        close_bank(1'b0);
        repeat (3) step();
        wr(1'b0, 3, 999, 1'b0);
        chk("wr_err_set", wr_err, 1'b1);
        chk("drain_bank_not_free", bank_free[0], 1'b0);
        wait_drain("err_drain", 40);
        for (int a = 0; a < 7; a++) push(1'b1, a, a + 500, 1'b0);
        push(1'b1, 7, 700, 1'b1);
        wr(1'b1, 7, 700, 1'b1);
        wait_drain("wr_close_len8", 30);
        chk("wr_err_sticky", wr_err, 1'b1);

        // Reset mid-drain at beat 10
        for (int a = 0; a < 32; a++) wr(1'b0, a, a + 800, 1'b0);
        for (int a = 0; a < 32; a++) push(1'b0, a, a + 800, a == 31);
        close_bank(1'b0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (rd_valid && rd_addr == 5'd10) found = 1'b1;
            else step();
        end
        chk("reach_beat10", found, 1'b1);
        reset  = 1'b1;
        mon_en = 1'b0;
        sb.delete();
        step();
        chk("mid_reset_rd_valid", rd_valid, 1'b0);
        chk("mid_reset_bank_free", bank_free, 2'b11);
        chk("mid_reset_wr_err", wr_err, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Close with no prior write: FULL for one cycle, no beats
        close_bank(1'b1);
        chk("empty_close_full", bank_free, 2'b01);
        step();
        chk("empty_close_back", bank_free, 2'b11);
        chk("empty_close_no_beat", rd_valid, 1'b0);
        step();
        chk("empty_close_no_beat2", rd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_gbf_dbuf.md
Name: psum_gbf_dbuf

Overview:
- Double-banked partial-sum global buffer directly downstream of the relative-memory accumulator.
- Absorbs the accumulator's 512-bit row writes (w_en / w_addr / w_num) into one of two 32-entry banks.
- Drains each closed bank, oldest first, to the output/DRAM side over a valid/ready stream.
- Reports per-bank availability so the accumulator can stall.

Parameters:
- DATA_BITWIDTH, 512, width of one buffer word.
- DEPTH, 32, entries per bank.
- ADDR_BITWIDTH, 5, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- w_en  in  1  write strobe from accumulator
- w_addr  in  ADDR_BITWIDTH  word address within bank
- w_num  in  1  target bank select
- w_data  in  DATA_BITWIDTH  word to write
- w_close  in  1  pulse: bank w_num is complete (driven from su_add_finish/conv_finish)
- bank_free  out  2  bit b=1: bank b is EMPTY or FILLING, so writes are allowed
- rd_valid  out  1  rd_data/rd_addr/rd_bank/rd_last are valid
- rd_ready  in  1  consumer accepts the current beat
- rd_data  out  DATA_BITWIDTH  drained word
- rd_addr  out  ADDR_BITWIDTH  address of the drained word
- rd_bank  out  1  bank being drained
- rd_last  out  1  final beat of the bank
- wr_err  out  1  sticky: write or close issued to a bank that is FULL or DRAIN

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is synchronous, active-high; it overrides all other inputs.

Reset values:
- Both banks EMPTY; bank_free=2'b11.
- rd_valid=0, rd_last=0, rd_addr=0, rd_bank=0, rd_data=0, wr_err=0.
- Length registers len[b]=0; drain-order FIFO cleared.
- Memory contents are not reset.

Per-bank FSM, states EMPTY, FILLING, FULL, DRAIN:
- EMPTY -> FILLING on w_en to that bank.
- EMPTY -> FULL on w_close with no prior write; len stays 0 and no drain beats are issued, so the bank returns to EMPTY next cycle.
- FILLING -> FULL on w_close.
- FULL -> DRAIN when selected by the drain arbiter.
- DRAIN -> EMPTY on the cycle after the rd_last beat handshakes.

Writes:
- A write in EMPTY or FILLING stores w_data at mem[w_num][w_addr].
- len[b] <= max(len[b], w_addr+1); width ADDR_BITWIDTH+1, so 32 is representable.
- A write or close to a bank in FULL or DRAIN is dropped and sets wr_err. wr_err clears only on reset.
- w_en and w_close to the same bank in the same cycle: the write is stored and included in len, then the bank goes FULL.

Drain:
- Banks enter a 2-entry order queue when they reach FULL; the oldest is drained first.
- Reads are issued for addresses 0..len-1 with 1-cycle memory latency into an output register plus a 1-entry skid, so rd_ready may deassert at any cycle without data loss.
- First rd_valid appears 2 cycles after the FULL transition.
- While rd_ready=1, one beat is delivered per cycle; a bank of 32 words drains in 32 consecutive cycles.
- rd_last=1 exactly when rd_addr=len-1.
- While rd_valid=1 and rd_ready=0, all rd_* outputs hold stable.

Concurrency and boundaries:
- The accumulator may fill the other bank during a drain; the write port and read port are fully concurrent.
- After one bank's rd_last handshake, the next queued bank's first beat follows with no bubble.
- w_addr wrap-around is not applicable: addresses are absolute within the bank.
- Reset mid-drain: the drain is aborted, rd_valid=0 on the next cycle, and both banks return to EMPTY.

Decomposition:
- Shared package (accel_pkg):
  - bank-state encoding (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2, DRAIN=2'd3)
  - GBF_DATA_BITWIDTH=512
  - PSUM_GBF_DEPTH=32
- Natural sub-module: gbf_bank_ram, a simple dual-port synchronous RAM (1 write, 1 read, 1-cycle read latency), instantiated twice.
- The FSMs, drain arbiter, and skid stay in the top level.

Test Plan:
- Fill and drain: write bank0 addr 0..31 with data=addr+100, pulse w_close, rd_ready=1 -> 32 beats rd_data 100..131, rd_bank=0, rd_last on beat 32 only; bank_free[0] returns to 1 one cycle after that beat.
- Partial bank: write bank1 addr 0..4, then w_close -> exactly 5 beats, rd_last at rd_addr=4.
- Backpressure: during a drain, toggle rd_ready 1,0,0,1 -> no beat lost or duplicated, outputs stable while rd_ready=0.
- Ping-pong: close bank0, then fill and close bank1 during bank0's drain -> bank0 beats, then bank1 beats with no idle cycle; order follows close order.
- Error: write to bank0 while in DRAIN -> wr_err=1 and drained data unchanged; a same-cycle w_en+w_close at addr 7 -> len=8.
- Reset mid-drain at beat 10 -> rd_valid=0 next cycle, bank_free=2'b11, wr_err=0.
